instruction_fetch_unit: RTL

- Consumes the current program counter value and performs one instruction-word read on the memory bus per fetch request.
- Latches the fetched word into an instruction register for decode.
- Detects misaligned PCs, bus errors and bus timeouts, and reports them as fetch faults to the exception logic, which then redirects the PC.
- Sits between the program counter register and the bus interface.

---
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: one bus word read per request, with
// misaligned-PC, bus-error and bus-timeout faults reported as one-cycle pulses.
module instruction_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES          = 255,
  parameter logic [31:0] INSTRUCTION_RESET_VALUE = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchStart,
  input  logic [31:0] programCounter,
  input  logic        fetchAbort,
  output logic        busRead,
  output logic [31:0] busAddress,
  input  logic        busReady,
  input  logic        busError,
  input  logic [31:0] busData,
  output logic [31:0] instructionRegister,
  output logic        fetchBusy,
  output logic        fetchDone,
  output logic        fetchFault,
  output logic [1:0]  faultCause,
  output logic [31:0] faultAddress
);

  localparam int unsigned    CW       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state,  w_next;
  logic [31:0]   r_addr,   w_addr;
  logic [31:0]   r_ir,     w_ir;
  logic          r_done,   w_done;
  logic          r_fault,  w_fault;
  logic [1:0]    r_cause,  w_cause;
  logic [31:0]   r_faddr,  w_faddr;
  logic [CW-1:0] r_cnt,    w_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_ir    <= INSTRUCTION_RESET_VALUE;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
      r_faddr <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr;
      r_ir    <= w_ir;
      r_done  <= w_done;
      r_fault <= w_fault;
      r_cause <= w_cause;
      r_faddr <= w_faddr;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_addr  = r_addr;
    w_ir    = r_ir;
    w_done  = 1'b0;
    w_fault = 1'b0;
    w_cause = r_cause;
    w_faddr = r_faddr;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (fetchStart) begin
          if (programCounter[1:0] == 2'b00) begin
            w_next = S_WAIT;
            w_addr = programCounter;
            w_cnt  = '0;
          end else begin
            w_fault = 1'b1;
            w_cause = CAUSE_MISALIGN;
            w_faddr = programCounter;
          end
        end
      end
      S_WAIT: begin
        // Abort outranks any bus response arriving on the same edge.
        if (fetchAbort) begin
          w_next = S_IDLE;
        end else if (busError) begin
          w_next  = S_IDLE;
          w_fault = 1'b1;
          w_cause = CAUSE_BUSERR;
          w_faddr = r_addr;
        end else if (busReady) begin
          w_next = S_IDLE;
          w_ir   = busData;
          w_done = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          w_next  = S_IDLE;
          w_fault = 1'b1;
          w_cause = CAUSE_TIMEOUT;
          w_faddr = r_addr;
        end else if (r_cnt != '1) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobe decoded from state so an async reset drops it without a clock.
  assign busRead             = (r_state == S_WAIT);
  assign fetchBusy           = busRead;
  assign busAddress          = r_addr;
  assign instructionRegister = r_ir;
  assign fetchDone           = r_done;
  assign fetchFault          = r_fault;
  assign faultCause          = r_cause;
  assign faultAddress        = r_faddr;

endmodule
